vliw_fetch_stage: RTL and testbench
===================================

Name: vliw_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the dual-slot VLIW pipeline.
- Each fetch returns one 48-bit bundle: a 32-bit base slot and a 16-bit compressed slot.
- Holds the PC and talks to instruction memory with a req/valid handshake. Buffers one bundle under stall and applies redirects from the jump (base) and branch (compressed) paths.
- Presents the registered bundle plus pre-extracted opcode/funct_3 fields directly to the base and compressed control decoders.

Parameters:
- PC_W, 32, PC and address width
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 6, byte increment per bundle

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_addr  out  PC_W  bundle fetch address
- imem_req  out  1  fetch request
- imem_rdata  in  48  [31:0] base instr, [47:32] compressed instr
- imem_valid  in  1  rdata valid; meaningful only while imem_req=1
- stall  in  1  ID stage cannot accept; hold IF/ID
- flush_a  in  1  redirect from base slot (jump / IF_Flush)
- target_a  in  PC_W  jump target
- flush_c  in  1  redirect from compressed slot (branch)
- target_c  in  PC_W  branch target
- id_valid  out  1  IF/ID holds a live bundle
- id_pc  out  PC_W  PC of the IF/ID bundle
- id_instr32  out  32  base instruction
- id_instrc  out  16  compressed instruction
- id_opcode  out  7  id_instr32[6:0]
- id_funct3  out  3  id_instr32[14:12]
- id_opcode_c  out  2  id_instrc[1:0]
- id_funct3_c  out  3  id_instrc[15:13]

Behaviour:
- **Reset (async, rst=1)**
  - pc=RESET_PC, state=BOOT, imem_req=0, skid empty, id_valid=0, id_pc=0.
  - id_instr32=32'h00000013 (addi x0,x0,0); id_instrc=16'h0001 (c.nop).
  - Field outputs derive from these values.
- **FSM states**
  - BOOT: req=0. Always goes to REQ next cycle.
  - REQ: req=1, imem_addr=pc, held stable until imem_valid=1.
  - HOLD: req=0; skid full, waiting for stall to drop.
- **Accept in REQ (imem_valid=1, no flush)**
  - stall=0: IF/ID <= {rdata, pc}, id_valid<=1, pc<=pc+PC_STEP (modulo 2^PC_W wrap), stay in REQ. Zero-wait memory therefore gives one bundle per cycle.
  - stall=1: skid <= {rdata, pc}, pc<=pc+PC_STEP, go to HOLD.
- **HOLD**
  - When stall=0: IF/ID <= skid, id_valid<=1, skid empties, go to REQ.
- **Stall with no new bundle**
  - IF/ID and id_valid hold unchanged.
- **Stall and id_valid consumption**
  - When stall=0 and nothing new is loaded, id_valid<=0 and the IF/ID payload resets to NOP encodings.
- **Flush** (flush_a | flush_c); overrides stall, imem_valid and state:
  - pc <= flush_a ? target_a : target_c. flush_a wins when both are high.
  - id_valid<=0, IF/ID payload <= NOP encodings, skid emptied, state <= REQ.
  - A same-cycle imem_valid response is discarded.
- **Request cancellation**
  - Deasserting imem_req, or changing imem_addr after a flush, cancels any outstanding request. Memory must tolerate this.
- **Output timing**
  - Field outputs are pure slices of the IF/ID register, with no added latency.
- **Latency**
  - Address issued in cycle N with imem_valid in cycle N means id_valid=1 in cycle N+1.

Test Plan:
- Reset release, zero-wait memory returning 48'hABCD_00500093 -> BOOT one cycle, then imem_addr=0,6,12…; id_instr32=32'h00500093, id_opcode=7'h13, id_funct3=0, id_instrc=16'hABCD, id_opcode_c=2'b01, id_funct3_c=3'b101.
- imem_valid delayed 3 cycles at addr 0 -> imem_addr holds 0 throughout; id_valid rises exactly 1 cycle after valid; pc=6 afterwards.
- stall=1 for 4 cycles while bundle at 6 returns -> IF/ID keeps bundle 0; skid takes bundle 6; req=0 in HOLD; on stall release id_pc=6, then fetch resumes at 12.
- flush_a=1 (target_a=0x100) with flush_c=1 (target_c=0x200) and imem_valid=1 in the same cycle -> next imem_addr=0x100; id_valid=0; id_instr32=32'h13; response dropped.
- flush_c during HOLD with stall=1 -> skid emptied, state REQ, imem_addr=target_c, id_valid=0 regardless of stall.
- rst asserted mid-WAIT -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vliw_fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the dual-slot VLIW core.
// Issues one 48-bit bundle fetch per cycle, buffers one bundle in a skid register
// while ID stalls, and redirects on base-slot jumps or compressed-slot branches.
//
// state | meaning
// BOOT  | first cycle out of reset, no request issued
// REQ   | request asserted at pc, waiting for imem_valid
// HOLD  | skid holds a bundle, waiting for stall to drop
module vliw_fetch_stage #(
  parameter int          PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int          PC_STEP  = 6
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic [47:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            stall,
  input  logic            flush_a,
  input  logic [PC_W-1:0] target_a,
  input  logic            flush_c,
  input  logic [PC_W-1:0] target_c,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_instr32,
  output logic [15:0]     id_instrc,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [1:0]      id_opcode_c,
  output logic [2:0]      id_funct3_c
);

  localparam logic [31:0] NOP32 = 32'h0000_0013;
  localparam logic [15:0] NOP16 = 16'h0001;

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [47:0]     skid, skid_n;
  logic [PC_W-1:0] skid_pc, skid_pc_n;
  logic            id_valid_n;
  logic [PC_W-1:0] id_pc_n;
  logic [31:0]     id_instr32_n;
  logic [15:0]     id_instrc_n;

  // The request is a pure function of state so it stays stable until the response.
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  // Decoder fields are direct slices of the IF/ID register.
  assign id_opcode   = id_instr32[6:0];
  assign id_funct3   = id_instr32[14:12];
  assign id_opcode_c = id_instrc[1:0];
  assign id_funct3_c = id_instrc[15:13];

  // State, PC, skid and IF/ID registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      skid       <= '0;
      skid_pc    <= '0;
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr32 <= NOP32;
      id_instrc  <= NOP16;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      skid       <= skid_n;
      skid_pc    <= skid_pc_n;
      id_valid   <= id_valid_n;
      id_pc      <= id_pc_n;
      id_instr32 <= id_instr32_n;
      id_instrc  <= id_instrc_n;
    end
  end

  // Next-state, PC and IF/ID load selection; a flush overrides everything else.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    skid_n       = skid;
    skid_pc_n    = skid_pc;
    id_valid_n   = id_valid;
    id_pc_n      = id_pc;
    id_instr32_n = id_instr32;
    id_instrc_n  = id_instrc;

    if (flush_a || flush_c) begin
      pc_n         = flush_a ? target_a : target_c;
      state_n      = REQ;
      id_valid_n   = 1'b0;
      id_pc_n      = '0;
      id_instr32_n = NOP32;
      id_instrc_n  = NOP16;
    end else begin
      case (state)
        BOOT: begin
          state_n = REQ;
          if (!stall) begin
            id_valid_n   = 1'b0;
            id_pc_n      = '0;
            id_instr32_n = NOP32;
            id_instrc_n  = NOP16;
          end
        end
        REQ: begin
          if (imem_valid) begin
            pc_n = pc + PC_W'(PC_STEP);
            if (!stall) begin
              id_valid_n   = 1'b1;
              id_pc_n      = pc;
              id_instr32_n = imem_rdata[31:0];
              id_instrc_n  = imem_rdata[47:32];
            end else begin
              skid_n    = imem_rdata;
              skid_pc_n = pc;
              state_n   = HOLD;
            end
          end else if (!stall) begin
            // Bundle consumed by ID and nothing new arrived.
            id_valid_n   = 1'b0;
            id_pc_n      = '0;
            id_instr32_n = NOP32;
            id_instrc_n  = NOP16;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_valid_n   = 1'b1;
            id_pc_n      = skid_pc;
            id_instr32_n = skid[31:0];
            id_instrc_n  = skid[47:32];
            state_n      = REQ;
          end
        end
        default: state_n = BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_fetch_stage.sv
// Directed bench for vliw_fetch_stage: a per-cycle vector table for the main
// fetch/stall/flush sequence plus hand sequences for delayed valid and async reset.
module tb_vliw_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [47:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        flush_a;
  logic [31:0] target_a;
  logic        flush_c;
  logic [31:0] target_c;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr32;
  logic [15:0] id_instrc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [1:0]  id_opcode_c;
  logic [2:0]  id_funct3_c;

  int n_total = 0;
  int n_pass  = 0;

  vliw_fetch_stage #(.PC_W(32), .RESET_PC(32'h0), .PC_STEP(6)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall),
    .flush_a(flush_a), .target_a(target_a),
    .flush_c(flush_c), .target_c(target_c),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_instr32(id_instr32), .id_instrc(id_instrc),
    .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_opcode_c(id_opcode_c), .id_funct3_c(id_funct3_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        valid;
    logic        fa;
    logic        fc;
    logic [31:0] ta;
    logic [31:0] tc;
    logic [47:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_idpc;
    logic [31:0] e_i32;
  } vec_t;

  vec_t vt[$];

  localparam logic [47:0] D0   = 48'hABCD_0050_0093;
  localparam logic [47:0] D6   = 48'h1234_00A0_0113;
  localparam logic [47:0] D12  = 48'h5678_0000_0033;
  localparam logic [47:0] D18  = 48'h9999_DEAD_BEEF;
  localparam logic [47:0] D100 = 48'h4321_0010_0093;
  localparam logic [47:0] D200 = 48'h2468_0020_0113;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic s, input logic v, input logic fa, input logic fc,
                     input logic [31:0] ta, input logic [31:0] tc, input logic [47:0] rd,
                     input logic er, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ep, input logic [31:0] ei);
    vec_t x;
    x.stall = s; x.valid = v; x.fa = fa; x.fc = fc; x.ta = ta; x.tc = tc; x.rdata = rd;
    x.e_req = er; x.e_addr = ea; x.e_idv = ev; x.e_idpc = ep; x.e_i32 = ei;
    vt.push_back(x);
  endtask

  task automatic idle_inputs();
    stall = 0; imem_valid = 0; flush_a = 0; flush_c = 0;
    target_a = 0; target_c = 0; imem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();

    // Each row: inputs applied this cycle, outputs expected before the next edge.
    //   stall vld fa fc ta       tc       rdata  req addr      idv idpc      instr32
    add(0, 0, 0, 0, 0,       0,       0,    0, 32'h0,   0, 32'h0,   32'h13);       // BOOT
    add(0, 1, 0, 0, 0,       0,       D0,   1, 32'h0,   0, 32'h0,   32'h13);
    add(1, 1, 0, 0, 0,       0,       D6,   1, 32'h6,   1, 32'h0,   D0[31:0]);
    add(1, 0, 0, 0, 0,       0,       0,    0, 32'hC,   1, 32'h0,   D0[31:0]);     // HOLD
    add(1, 0, 0, 0, 0,       0,       0,    0, 32'hC,   1, 32'h0,   D0[31:0]);
    add(1, 0, 0, 0, 0,       0,       0,    0, 32'hC,   1, 32'h0,   D0[31:0]);
    add(0, 0, 0, 0, 0,       0,       0,    0, 32'hC,   1, 32'h0,   D0[31:0]);
    add(0, 0, 0, 0, 0,       0,       0,    1, 32'hC,   1, 32'h6,   D6[31:0]);     // skid out
    add(0, 1, 0, 0, 0,       0,       D12,  1, 32'hC,   0, 32'h0,   32'h13);
    add(0, 1, 1, 1, 32'h100, 32'h200, D18,  1, 32'h12,  1, 32'hC,   D12[31:0]);    // dual flush
    add(0, 0, 0, 0, 0,       0,       0,    1, 32'h100, 0, 32'h0,   32'h13);
    add(1, 1, 0, 0, 0,       0,       D100, 1, 32'h100, 0, 32'h0,   32'h13);
    add(1, 0, 0, 1, 0,       32'h200, 0,    0, 32'h106, 0, 32'h0,   32'h13);       // flush_c in HOLD
    add(1, 0, 0, 0, 0,       0,       0,    1, 32'h200, 0, 32'h0,   32'h13);
    add(0, 0, 0, 0, 0,       0,       0,    1, 32'h200, 0, 32'h0,   32'h13);       // skid was emptied
    add(0, 1, 0, 0, 0,       0,       D200, 1, 32'h200, 0, 32'h0,   32'h13);
    add(0, 0, 0, 0, 0,       0,       0,    1, 32'h206, 1, 32'h200, D200[31:0]);

    // Reset values and field slices, checked while rst is still high.
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_idv", id_valid, 1'b0);
    chk("rst_idpc", id_pc, 32'h0);
    chk("rst_i32", id_instr32, 32'h13);
    chk("rst_ic", id_instrc, 16'h0001);
    chk("rst_op", id_opcode, 7'h13);
    chk("rst_f3", id_funct3, 3'h0);
    chk("rst_opc", id_opcode_c, 2'b01);
    chk("rst_f3c", id_funct3_c, 3'b000);

    @(negedge clk);
    rst = 0;
    for (int i = 0; i < vt.size(); i++) begin
      if (i != 0) @(negedge clk);
      stall = vt[i].stall; imem_valid = vt[i].valid;
      flush_a = vt[i].fa; flush_c = vt[i].fc;
      target_a = vt[i].ta; target_c = vt[i].tc; imem_rdata = vt[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i),  imem_req,   vt[i].e_req);
      chk($sformatf("v%0d_addr", i), imem_addr,  vt[i].e_addr);
      chk($sformatf("v%0d_idv", i),  id_valid,   vt[i].e_idv);
      chk($sformatf("v%0d_idpc", i), id_pc,      vt[i].e_idpc);
      chk($sformatf("v%0d_i32", i),  id_instr32, vt[i].e_i32);
    end

    // Delayed response: address must hold for 3 wait cycles, id_valid one cycle after valid.
    do_reset();
    #1 chk("dly_boot_req", imem_req, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("dly_w%0d_req", k), imem_req, 1'b1);
      chk($sformatf("dly_w%0d_addr", k), imem_addr, 32'h0);
      chk($sformatf("dly_w%0d_idv", k), id_valid, 1'b0);
    end
    @(negedge clk);
    imem_valid = 1; imem_rdata = D0;
    #1 chk("dly_v_addr", imem_addr, 32'h0);
    chk("dly_v_idv", id_valid, 1'b0);
    @(negedge clk);
    imem_valid = 0;
    #1;
    chk("dly_idv", id_valid, 1'b1);
    chk("dly_addr", imem_addr, 32'h6);
    chk("dly_i32", id_instr32, 32'h0050_0093);
    chk("dly_op", id_opcode, 7'h13);
    chk("dly_f3", id_funct3, 3'h0);
    chk("dly_ic", id_instrc, 16'hABCD);
    chk("dly_opc", id_opcode_c, 2'b01);
    chk("dly_f3c", id_funct3_c, 3'b101);

    // Async reset while waiting in REQ with a live bundle held by stall.
    stall = 1;
    @(negedge clk); #1;
    chk("ar_pre_idv", id_valid, 1'b1);
    chk("ar_pre_req", imem_req, 1'b1);
    #2 rst = 1;
    #1;
    chk("ar_req", imem_req, 1'b0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_idv", id_valid, 1'b0);
    chk("ar_idpc", id_pc, 32'h0);
    chk("ar_i32", id_instr32, 32'h13);
    chk("ar_ic", id_instrc, 16'h0001);
    @(negedge clk);
    rst = 0;
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
